// File: rtl/pipelined_control_unit.sv
// ID-stage main decoder with ID/EX control register, load-use stall detection
// and branch/jump squashing over FLUSH_DEPTH consecutive ID slots.
//
// state    | meaning
// ST_RUN   | normal issue; squash only on a redirect seen this cycle
// ST_FLUSH | squashing the remaining slots after a redirect; cnt counts them down
module pipelined_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_branch_taken,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  illegal_op
);

  localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  ctrl_t                 ctrl_q, ctrl_d, dec;
  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic                  illegal_q, illegal_d;
  logic                  legal, stall, redirect, squash;
  logic [5:0]            op6;

  assign op6 = id_opcode[5:0];

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (op6)
      6'b000000: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
      6'b100011: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      6'b101011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      6'b000100: begin dec.branch = 1'b1; dec.alu_op = 2'b01; end
      6'b001000: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      6'b000010: dec.jump = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  // Register 0 never carries a loaded value, so a load into it cannot hazard.
  assign stall = id_valid & valid_q & ctrl_q.mem_read & (rt_q != '0) &
                 ((rt_q == id_rs) | (rt_q == id_rt));
  assign redirect = ex_branch_taken | (valid_q & ctrl_q.jump);
  assign squash   = redirect | (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_RUN) begin
      if (redirect && (FLUSH_DEPTH > 1)) begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_LOAD;
      end
    end else if (redirect) begin
      cnt_d = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = ST_RUN;
    end
  end

  always_comb begin
    ctrl_d         = '0;
    valid_d        = 1'b0;
    rt_d           = '0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    if (squash) begin
      if_id_flush = 1'b1;
    end else if (stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
    end else if (id_valid) begin
      ctrl_d  = dec;
      valid_d = legal;
      rt_d    = id_rt;
    end
    illegal_d = illegal_q | (id_valid & ~legal & ~squash);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rt_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      rt_q      <= rt_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_jump       = ctrl_q.jump;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_valid      = valid_q;
  assign ex_rt         = rt_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: three instances (FLUSH_DEPTH 1..3) share
// stimulus and are each compared against a cycle-level reference model.
module tb_pipelined_control_unit;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] OPS [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       br;

  wire [9:0] w_bund [3];
  wire       w_valid [3];
  wire [4:0] w_rt [3];
  wire       w_ill [3];
  wire       w_pcwe [3];
  wire       w_ifwe [3];
  wire       w_flush [3];

  int n_vec = 0;
  int n_err = 0;

  // model state: bundle bits {reg_dst,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,jump,alu_op[1:0]}
  logic [9:0] m_bund [3];
  logic       m_valid [3];
  logic [4:0] m_rt [3];
  logic       m_rt_chk [3];
  logic       m_ill [3];
  int         m_left [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic rd, bo, mr, mtr, mw, as, rw, jp;
    logic [1:0] ao;
    pipelined_control_unit #(.OPCODE_W(6), .REG_ADDR_W(5), .FLUSH_DEPTH(g + 1)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .ex_branch_taken(br),
      .ex_reg_dst(rd), .ex_branch(bo), .ex_mem_read(mr), .ex_mem_to_reg(mtr),
      .ex_mem_write(mw), .ex_alu_src(as), .ex_reg_write(rw), .ex_jump(jp),
      .ex_alu_op(ao), .ex_valid(w_valid[g]), .ex_rt(w_rt[g]),
      .pc_write_en(w_pcwe[g]), .if_id_write_en(w_ifwe[g]),
      .if_id_flush(w_flush[g]), .illegal_op(w_ill[g])
    );
    assign w_bund[g] = {rd, bo, mr, mtr, mw, as, rw, jp, ao};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {legal, bundle} straight from the opcode table
  function automatic logic [10:0] ref_dec(input logic [5:0] op);
    case (op)
      OP_R:    return {1'b1, 10'b1000001010};
      OP_LW:   return {1'b1, 10'b0011011000};
      OP_SW:   return {1'b1, 10'b0000110000};
      OP_BEQ:  return {1'b1, 10'b0100000001};
      OP_ADDI: return {1'b1, 10'b0000011000};
      OP_J:    return {1'b1, 10'b0000000100};
      default: return 11'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      m_bund[g] = '0; m_valid[g] = 1'b0; m_rt[g] = '0; m_rt_chk[g] = 1'b1;
      m_ill[g] = 1'b0; m_left[g] = 0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s bundle d%0d", tag, g + 1), 32'(w_bund[g]), 32'd0);
      chk($sformatf("%s ex_valid d%0d", tag, g + 1), 32'(w_valid[g]), 32'd0);
      chk($sformatf("%s ex_rt d%0d", tag, g + 1), 32'(w_rt[g]), 32'd0);
      chk($sformatf("%s illegal d%0d", tag, g + 1), 32'(w_ill[g]), 32'd0);
      chk($sformatf("%s pc_we d%0d", tag, g + 1), 32'(w_pcwe[g]), 32'd1);
      chk($sformatf("%s ifid_we d%0d", tag, g + 1), 32'(w_ifwe[g]), 32'd1);
      chk($sformatf("%s flush d%0d", tag, g + 1), 32'(w_flush[g]), 32'd0);
    end
  endtask

  // Entered and left at a falling edge; reset is asserted well away from any rising edge.
  task automatic do_reset(input string tag);
    id_valid = 1'b0; br = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic b);
    logic [10:0] d;
    logic        redir, stall, squash;
    logic [9:0]  nb [3];
    logic        nv [3], nrc [3], ni [3];
    logic [4:0]  nr [3];
    int          nl [3];
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; br = b;
    #1;
    d = ref_dec(op);
    for (int g = 0; g < 3; g++) begin
      redir  = b || (m_valid[g] && m_bund[g][2]);
      stall  = v && m_valid[g] && m_bund[g][7] && (m_rt[g] != 5'd0) &&
               ((m_rt[g] == rs) || (m_rt[g] == rt));
      squash = redir || (m_left[g] > 0);
      chk($sformatf("pc_we d%0d", g + 1), 32'(w_pcwe[g]), 32'(squash || !stall));
      chk($sformatf("ifid_we d%0d", g + 1), 32'(w_ifwe[g]), 32'(squash || !stall));
      chk($sformatf("flush d%0d", g + 1), 32'(w_flush[g]), 32'(squash));
      if (squash || stall || !v) begin
        nb[g] = '0; nv[g] = 1'b0; nr[g] = '0; nrc[g] = 1'b1;
      end else begin
        nb[g] = d[9:0]; nv[g] = d[10]; nr[g] = rt; nrc[g] = d[10];
      end
      ni[g] = m_ill[g] || (v && !d[10] && !squash);
      if (redir) nl[g] = g;
      else if (m_left[g] > 0) nl[g] = m_left[g] - 1;
      else nl[g] = 0;
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      m_bund[g] = nb[g]; m_valid[g] = nv[g]; m_rt[g] = nr[g];
      m_rt_chk[g] = nrc[g]; m_ill[g] = ni[g]; m_left[g] = nl[g];
      chk($sformatf("bundle d%0d", g + 1), 32'(w_bund[g]), 32'(m_bund[g]));
      chk($sformatf("ex_valid d%0d", g + 1), 32'(w_valid[g]), 32'(m_valid[g]));
      if (m_rt_chk[g]) chk($sformatf("ex_rt d%0d", g + 1), 32'(w_rt[g]), 32'(m_rt[g]));
      chk($sformatf("illegal d%0d", g + 1), 32'(w_ill[g]), 32'(m_ill[g]));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; br = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0;
    model_reset();
    @(negedge clk);
    do_reset("por");

    // decode sweep; the trailing j redirects, so drain afterwards
    for (int i = 0; i < 6; i++) step(1'b1, OPS[i], 5'd1, 5'd2, 1'b0);
    chk("j ex_jump", 32'(w_bund[0][2]), 32'd1);
    chk("j ex_reg_write", 32'(w_bund[0][3]), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, OP_R, 5'd0, 5'd0, 1'b0);

    // load-use with rt=5, then with rt=0
    step(1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    step(1'b1, OP_R, 5'd5, 5'd6, 1'b0);
    chk("stall bubble", 32'(w_valid[1]), 32'd0);
    step(1'b1, OP_R, 5'd5, 5'd6, 1'b0);
    chk("add after stall alu_op", 32'(w_bund[1][1:0]), 32'd2);
    step(1'b1, OP_LW, 5'd1, 5'd0, 1'b0);
    step(1'b1, OP_R, 5'd0, 5'd6, 1'b0);

    // branch flush, then stall coinciding with a taken branch
    step(1'b1, OP_ADDI, 5'd1, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, OP_ADDI, 5'd1, 5'd2, 1'b0);
    step(1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    step(1'b1, OP_R, 5'd5, 5'd6, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, OP_R, 5'd0, 5'd0, 1'b0);

    // squashed illegal must not latch; unsquashed one is sticky
    do_reset("rst2");
    step(1'b1, OP_BAD, 5'd1, 5'd2, 1'b1);
    chk("squashed illegal", 32'(w_ill[0]), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, OP_R, 5'd0, 5'd0, 1'b0);
    step(1'b1, OP_BAD, 5'd1, 5'd2, 1'b0);
    chk("illegal set", 32'(w_ill[2]), 32'd1);
    step(1'b1, OP_R, 5'd1, 5'd2, 1'b0);
    step(1'b1, OP_SW, 5'd1, 5'd2, 1'b0);

    // reset in the middle of a depth-3 flush
    step(1'b1, OP_ADDI, 5'd1, 5'd2, 1'b1);
    step(1'b1, OP_ADDI, 5'd1, 5'd2, 1'b0);
    do_reset("midflush");
    step(1'b1, OP_ADDI, 5'd3, 5'd4, 1'b0);
    step(1'b1, OP_R, 5'd3, 5'd4, 1'b0);

    do_reset("rst3");
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [5:0] op;
      k = $urandom_range(0, 39);
      if (k < 36) op = OPS[k % 6];
      else if (k < 38) op = OP_BAD;
      else op = 6'($urandom);
      step(($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised successor to the single-cycle main decoder: decodes the ID-stage opcode into the control bundle and registers it into the ID/EX pipeline register. It also owns load-use hazard detection (stall plus bubble) and branch/jump squashing (flush plus bubble, configurable depth). It sits between the IF/ID register and the EX stage of the 5-stage pipeline and drives the PC and IF/ID write enables.

## Interface

- OPCODE_W, 6, opcode width; must be ≥ 6, and only the low 6 bits are decoded.
- REG_ADDR_W, 5, register-index width.
- FLUSH_DEPTH, 1, number of consecutive ID slots squashed per redirect; legal range is 1..3.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_opcode  in  OPCODE_W  opcode of the ID instruction.
- id_rs, id_rt  in  REG_ADDR_W  source register indices of the ID instruction.
- ex_branch_taken  in  1  EX resolved a taken beq this cycle.
- ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump  out  1 each  registered ID/EX control bundle.
- ex_alu_op  out  2  registered ALU op class.
- ex_valid  out  1  ID/EX slot holds a real instruction.
- ex_rt  out  REG_ADDR_W  registered id_rt, used for hazard compare.
- pc_write_en, if_id_write_en  out  1  combinational enables; low means stall.
- if_id_flush  out  1  combinational; IF/ID is cleared on the next edge.
- illegal_op  out  1  registered sticky flag; cleared only by rst.

## Operation

- Decode (combinational; any signal not listed is 0; no X is ever driven):
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00.
  - 101011 sw: mem_write=1, alu_src=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00.
  - 000010 j: jump=1. reg_write=0 and alu_src=0.
- Any other opcode with id_valid=1 decodes to an all-zero bundle with valid=0 and sets illegal_op.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Redirect: redirect = ex_branch_taken | (ex_valid & ex_jump).
- FSM, states RUN and FLUSH, with down-counter cnt of width clog2(FLUSH_DEPTH+1):
  - In RUN, redirect with FLUSH_DEPTH > 1 moves to FLUSH with cnt = FLUSH_DEPTH-1.
  - In FLUSH, cnt decrements each cycle; when cnt reaches 1 and decrements, the FSM returns to RUN.
  - A new redirect while in FLUSH reloads cnt to FLUSH_DEPTH-1.
- Squash = redirect | (state == FLUSH).
- Each cycle's ID/EX load, in priority order:
  - Squash: load a bubble (all bundle bits 0, ex_valid=0, ex_rt=0). Outputs are if_id_flush=1, pc_write_en=1, if_id_write_en=1.
  - Else stall: load a bubble. Outputs are pc_write_en=0, if_id_write_en=0, if_id_flush=0.
  - Else: load the decoded bundle, ex_valid = id_valid & legal, ex_rt = id_rt. Both enables are 1 and if_id_flush=0.
- A squashed illegal opcode does not set illegal_op.
- id_valid=0 loads a bubble and never stalls.

## Timing

- Decode to ex_* latency is 1 cycle: the opcode presented in cycle N appears on ex_* after edge N.
- Load-use stall lasts exactly 1 cycle. The bubble clears ex_mem_read, so the instruction re-evaluates and issues on the next cycle.
- Redirect squashes the ID instruction in the same cycle, followed by FLUSH_DEPTH-1 further cycles.
- Simultaneous stall and redirect: squash wins and the PC is not frozen.
- Reset (asynchronous, any time, including mid-flush or mid-stall):
  - All ex_* outputs = 0, ex_valid=0, illegal_op=0, state=RUN, cnt=0.
  - Combinational outputs settle to pc_write_en=1, if_id_write_en=1, if_id_flush=0 (given id_valid=0).
- After rst deasserts, the first edge loads normally.

## Test plan

- Decode sweep: each of the six opcodes with id_valid=1 and no hazard. On the next cycle ex_* matches the decode table exactly, with ex_valid=1. j gives ex_jump=1 and ex_reg_write=0.
- Load-use:
  - lw with rt=5, followed by add with rs=5: exactly 1 cycle with pc_write_en=0 and if_id_write_en=0, ex_valid=0 for that cycle, then the add bundle with reg_dst=1 and alu_op=10.
  - Same sequence with rt=0: no stall.
- Branch flush with FLUSH_DEPTH=2: pulse ex_branch_taken for 1 cycle. if_id_flush=1 for 2 consecutive cycles, ex_valid=0 in both following slots, pc_write_en stays 1.
- Priority: lw hazard coinciding with ex_branch_taken. Expect if_id_flush=1, pc_write_en=1, and a bubble loaded.
- Illegal opcode 111111: ex_valid=0, illegal_op=1 and it stays 1 across subsequent legal instructions. If the same opcode is squashed by a redirect, illegal_op stays 0.
- Reset mid-flush: assert rst in the middle of a FLUSH_DEPTH=3 sequence. All outputs go to 0 immediately (asynchronously). After release, the next opcode issues normally with no residual flush.
